// File: rtl/md5_guess_generator.sv
// Brute-force candidate generator for the MD5 pipeline: enumerates every
// string over [CHAR_MIN, CHAR_MAX] for lengths start_len..end_len, byte 0 in guess[127:120].
module md5_guess_generator #(
  parameter logic [7:0]  CHAR_MIN = 8'h20,
  parameter logic [7:0]  CHAR_MAX = 8'h7E,
  parameter int unsigned INDEX_W  = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [3:0]         start_len,
  input  logic [3:0]         end_len,
  input  logic               out_ready,
  output logic               guess_valid,
  output logic [127:0]       guess,
  output logic [3:0]         guesslen,
  output logic [INDEX_W-1:0] guess_index,
  output logic               busy,
  output logic               done,
  output logic               cfg_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e state_q, state_d;

  // Element e of the packed array holds byte position 15-e, so element 15 is guess[127:120].
  logic [15:0][7:0]   guess_q, guess_d;
  logic [15:0][7:0]   odo_bytes;
  logic               odo_carry;
  logic [3:0]         guesslen_q, guesslen_d;
  logic [3:0]         end_len_q, end_len_d;
  logic [INDEX_W-1:0] index_q, index_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               cfg_err_q, cfg_err_d;

  logic xfer;
  logic cfg_ok;
  logic len_done;

  assign xfer     = valid_q && out_ready;
  assign cfg_ok   = (start_len != 4'd0) && (start_len <= end_len);
  assign len_done = (guesslen_q >= end_len_q);

  // Odometer step over the active bytes; the rightmost active byte ticks fastest.
  always_comb begin
    odo_bytes = guess_q;
    odo_carry = 1'b1;
    for (int e = 0; e < 16; e++) begin
      if (odo_carry && ((5'(e) + {1'b0, guesslen_q}) >= 5'd16)) begin
        if (guess_q[4'(e)] == CHAR_MAX) begin
          odo_bytes[4'(e)] = CHAR_MIN;
        end else begin
          odo_bytes[4'(e)] = guess_q[4'(e)] + 8'd1;
          odo_carry        = 1'b0;
        end
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = cfg_ok ? RUN : DONE;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (xfer && odo_carry && len_done) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (abort) begin
          state_d = IDLE;
        end else if (start) begin
          state_d = cfg_ok ? RUN : DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    guess_d    = guess_q;
    guesslen_d = guesslen_q;
    end_len_d  = end_len_q;
    index_d    = index_q;
    cfg_err_d  = cfg_err_q;
    valid_d    = (state_d == RUN);
    busy_d     = (state_d == RUN);
    done_d     = (state_d == DONE);

    case (state_q)
      IDLE, DONE: begin
        if (start && !(state_q == DONE && abort)) begin
          cfg_err_d = !cfg_ok;
          if (cfg_ok) begin
            guesslen_d = start_len;
            end_len_d  = end_len;
            index_d    = '0;
            for (int e = 0; e < 16; e++) begin
              guess_d[4'(e)] = ((5'(e) + {1'b0, start_len}) >= 5'd16) ? CHAR_MIN : 8'h00;
            end
          end
        end
      end
      RUN: begin
        if (xfer && !abort) begin
          index_d = index_q + INDEX_W'(1);
          if (!odo_carry) begin
            guess_d = odo_bytes;
          end else if (!len_done) begin
            // Length rollover: every old byte already wrapped to CHAR_MIN; activate one more.
            guess_d                      = odo_bytes;
            guess_d[4'd15 - guesslen_q]  = CHAR_MIN;
            guesslen_d                   = guesslen_q + 4'd1;
          end
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      guess_q    <= '0;
      guesslen_q <= '0;
      end_len_q  <= '0;
      index_q    <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      guess_q    <= guess_d;
      guesslen_q <= guesslen_d;
      end_len_q  <= end_len_d;
      index_q    <= index_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

  assign guess_valid = valid_q;
  assign guess       = guess_q;
  assign guesslen    = guesslen_q;
  assign guess_index = index_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign cfg_err     = cfg_err_q;

endmodule

// File: doc/md5_guess_generator.md
Name: md5_guess_generator

Overview:
Brute-force candidate source that drives the guess/guesslen inputs of the MD5 hash pipeline. It enumerates every string over a contiguous byte charset, for each length from start_len to end_len. The output format matches the pipeline input exactly: byte 0 is at guess[127:120] and unused bytes are zero. Each guess carries a sequence index so downstream match logic can recover the candidate that produced a hit.

Parameters:
CHAR_MIN, 8'h20, lowest charset byte (inclusive)
CHAR_MAX, 8'h7E, highest charset byte (inclusive); CHAR_MIN <= CHAR_MAX required
INDEX_W, 64, width of guess_index

Ports:
clk  in  1  clock; all logic on posedge
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; latches start_len/end_len and begins enumeration
abort  in  1  stops enumeration and returns to IDLE
start_len  in  4  first length, valid range 1..15
end_len  in  4  last length, valid range start_len..15
out_ready  in  1  consumer ready; tie high for the free-running pipeline
guess_valid  out  1  guess/guesslen/guess_index valid
guess  out  128  candidate; byte i at [127-8i -: 8]
guesslen  out  4  candidate length in bytes
guess_index  out  INDEX_W  0-based ordinal of candidate since start
busy  out  1  high in RUN
done  out  1  high in DONE
cfg_err  out  1  last start had an illegal length config

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, port reset.
- Reset value of all outputs is 0. State goes to IDLE. Reset wins over start and abort in the same cycle, and works mid-run.
- States: IDLE, RUN, DONE.
- IDLE, start=1:
  - If start_len==0 or start_len>end_len: cfg_err<=1, go to DONE, guess_valid stays 0.
  - Otherwise: cfg_err<=0, load guesslen=start_len, set bytes 0..start_len-1 to CHAR_MIN and others to 0, guess_index<=0, guess_valid<=1, go to RUN.
  - Latency: start sampled at cycle N gives the first valid guess at N+1.
- RUN:
  - A transfer occurs on guess_valid && out_ready.
  - With no transfer, all outputs hold stable.
  - On transfer, advance the odometer and increment guess_index (wraps modulo 2^INDEX_W, no flag).
- Odometer:
  - The byte at position guesslen-1 increments fastest.
  - A byte equal to CHAR_MAX resets to CHAR_MIN and carries to the position on its left.
  - Carry out of byte 0 means the length is exhausted:
    - if guesslen < end_len: guesslen+1, all active bytes reset to CHAR_MIN, the newly active byte included.
    - else, the final candidate was just transferred: guess_valid<=0, go to DONE. guess and guesslen hold their last value.
  - Bytes at positions >= guesslen are always 0.
- Total candidates = sum over L=start_len..end_len of (CHAR_MAX-CHAR_MIN+1)^L.
- start in RUN is ignored.
- abort in RUN or DONE: guess_valid<=0, busy<=0, done<=0, go to IDLE the next cycle. abort takes priority over a simultaneous transfer, and the transfer is not counted.
- DONE: done=1, busy=0. start behaves as in IDLE, clearing done on a legal config. abort returns to IDLE.
- Outputs are registered; there is no combinational path from inputs to outputs.

Test Plan:
- CHAR_MIN=0x61, CHAR_MAX=0x63, start_len=1, end_len=2, out_ready=1, start pulse:
  - exactly 12 guesses: a,b,c,aa,ab,ac,ba,...,cc, with guess_index 0..11.
  - first guess = 128'h61 followed by 120 zero bits, guesslen=1.
  - index 3 guess = 128'h6161 followed by zeros, guesslen=2.
  - done=1 the cycle after the index-11 transfer.
- Same config, drop out_ready for 3 cycles at index 5:
  - guess, guesslen and guess_index=5 hold unchanged.
  - the sequence resumes with no skips or duplicates.
- start with start_len=0, or start_len=4/end_len=3 -> cfg_err=1, done=1 next cycle, guess_valid never asserts.
- CHAR_MIN=CHAR_MAX=0x41, start_len=end_len=15 -> one guess with bytes 0..14=0x41, guess[7:0]=0, guesslen=15, then done.
- reset asserted mid-RUN at index 7 -> next cycle all outputs 0 and IDLE; a new start restarts at index 0.
- abort at index 4 together with out_ready=1 -> guess_valid=0 next cycle, state IDLE, done=0; a subsequent start restarts at index 0.
